camera_i2c_arbiter: RTL and testbench

Arbitrates the single camera-side I2C bus between two masters: requester 0 is the camera sensor register-configuration engine, and requester 1 is the VCM focus-step engine. Bus ownership is held off until the MIPI bridge configuration reports release. Ownership is granted on a round-robin basis, with a guard gap between owners and a watchdog that revokes a stuck owner. The muxed, registered SCL and SDA pull-down drive go to the camera connector pins. This block replaces the hard-wired SCL select in the camera config top level.

---
 rtl/camera_i2c_arbiter.sv | 153 +++++++++++++++
 tb/tb_camera_i2c_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/camera_i2c_arbiter.sv
// Round-robin owner of the camera-side I2C bus for the sensor config engine (0) and the VCM engine (1).
// Held in BOOT until the MIPI bridge releases; guard gap between owners, watchdog on each grant.
module camera_i2c_arbiter #(
  parameter int unsigned GUARD_CYCLES   = 250,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic       CLK_50,
  input  logic       RESET_N,
  input  logic       BRIDGE_RELEASE,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       DONE0,
  input  logic       DONE1,
  input  logic       SCL0,
  input  logic       SCL1,
  input  logic       SDA_OE0,
  input  logic       SDA_OE1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       CAMERA_I2C_SCL,
  output logic       CAMERA_I2C_SDA_OE,
  output logic       BUSY,
  output logic [1:0] TIMEOUT_ERR
);

  typedef enum logic [2:0] {BOOT, IDLE, OWN0, OWN1, GUARD} state_t;

  localparam logic [31:0] GUARD_LAST   = 32'(GUARD_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [1:0]  terr_q, terr_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        scl_q, scl_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= BOOT;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      terr_q   <= 2'b00;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      terr_q   <= terr_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
    end
  end

  // One counter serves both the grant watchdog and the guard gap; it is cleared on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    terr_d  = terr_q;
    if (state_q != BOOT && !BRIDGE_RELEASE) begin
      state_d = BOOT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        BOOT: begin
          if (BRIDGE_RELEASE) state_d = IDLE;
        end
        IDLE: begin
          if (REQ0 && (!REQ1 || last_q)) begin
            state_d = OWN0;
            last_d  = 1'b0;
            cnt_d   = '0;
          end else if (REQ1) begin
            state_d = OWN1;
            last_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        OWN0: begin
          if (DONE0 || !REQ0) begin
            state_d = GUARD;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = GUARD;
            cnt_d     = '0;
            terr_d[0] = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        OWN1: begin
          if (DONE1 || !REQ1) begin
            state_d = GUARD;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = GUARD;
            cnt_d     = '0;
            terr_d[1] = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: begin
          state_d = BOOT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so the bus is handed over and released on the deciding edge.
  always_comb begin
    gnt0_d   = (state_d == OWN0);
    gnt1_d   = (state_d == OWN1);
    busy_d   = (state_d == OWN0) || (state_d == OWN1) || (state_d == GUARD);
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    if (state_d == OWN0) begin
      scl_d    = SCL0;
      sda_oe_d = SDA_OE0;
    end else if (state_d == OWN1) begin
      scl_d    = SCL1;
      sda_oe_d = SDA_OE1;
    end
  end

  assign GNT0              = gnt0_q;
  assign GNT1              = gnt1_q;
  assign CAMERA_I2C_SCL    = scl_q;
  assign CAMERA_I2C_SDA_OE = sda_oe_q;
  assign BUSY              = busy_q;
  assign TIMEOUT_ERR       = terr_q;

endmodule

// File: tb/tb_camera_i2c_arbiter.sv
// Bench for camera_i2c_arbiter: vector table, directed corner sequences, then random traffic vs a reference model.
module tb_camera_i2c_arbiter;
  localparam int G = 4;
  localparam int T = 20;

  logic       CLK_50 = 1'b0;
  logic       RESET_N = 1'b0;
  logic       BRIDGE_RELEASE = 1'b0;
  logic       REQ0 = 1'b0, REQ1 = 1'b0, DONE0 = 1'b0, DONE1 = 1'b0;
  logic       SCL0 = 1'b1, SCL1 = 1'b1, SDA_OE0 = 1'b0, SDA_OE1 = 1'b0;
  logic       GNT0, GNT1, CAMERA_I2C_SCL, CAMERA_I2C_SDA_OE, BUSY;
  logic [1:0] TIMEOUT_ERR;

  int n_pass = 0;
  int n_total = 0;

  camera_i2c_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .CLK_50(CLK_50), .RESET_N(RESET_N), .BRIDGE_RELEASE(BRIDGE_RELEASE),
    .REQ0(REQ0), .REQ1(REQ1), .DONE0(DONE0), .DONE1(DONE1),
    .SCL0(SCL0), .SCL1(SCL1), .SDA_OE0(SDA_OE0), .SDA_OE1(SDA_OE1),
    .GNT0(GNT0), .GNT1(GNT1), .CAMERA_I2C_SCL(CAMERA_I2C_SCL),
    .CAMERA_I2C_SDA_OE(CAMERA_I2C_SDA_OE), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK_50 = ~CLK_50;

  // {in: br,req0,req1,done0,done1,scl0,oe0,scl1,oe1} -> {exp: gnt1,gnt0,scl,oe,busy,err[1:0]}
  typedef struct {
    logic [8:0] in;
    logic [6:0] exp;
  } vec_t;
  vec_t vt[12];

  function automatic logic [6:0] outs();
    return {GNT1, GNT0, CAMERA_I2C_SCL, CAMERA_I2C_SDA_OE, BUSY, TIMEOUT_ERR};
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endfunction

  task automatic do_reset();
    @(negedge CLK_50);
    RESET_N = 1'b0;
    {BRIDGE_RELEASE, REQ0, REQ1, DONE0, DONE1} = 5'b0;
    {SCL0, SDA_OE0, SCL1, SDA_OE1} = 4'b1010;
    @(negedge CLK_50);
    RESET_N = 1'b1;
  endtask

  // Reference model: owner index, remaining guard cycles and grant age, stepped on each sampling edge.
  bit         m_booted;
  int         m_owner, m_guard, m_age, m_last;
  logic [1:0] m_err;
  logic       e_g0, e_g1, e_scl, e_oe, e_busy;

  always @(posedge CLK_50 or negedge RESET_N) begin
    logic [1:0] rq, dn, sc, so;
    rq = {REQ1, REQ0};
    dn = {DONE1, DONE0};
    sc = {SCL1, SCL0};
    so = {SDA_OE1, SDA_OE0};
    if (!RESET_N) begin
      m_booted = 0; m_owner = -1; m_guard = 0; m_age = 0; m_last = 1; m_err = 2'b00;
      e_g0 = 0; e_g1 = 0; e_scl = 1; e_oe = 0; e_busy = 0;
    end else begin
      if (!m_booted) m_booted = BRIDGE_RELEASE;
      else if (!BRIDGE_RELEASE) begin
        m_booted = 0; m_owner = -1; m_guard = 0;
      end else if (m_owner >= 0) begin
        if (dn[m_owner[0]] || !rq[m_owner[0]]) begin
          m_owner = -1; m_guard = G;
        end else if (m_age >= T) begin
          m_err[m_owner[0]] = 1'b1; m_owner = -1; m_guard = G;
        end else m_age++;
      end else if (m_guard > 0) m_guard--;
      else if (rq != 2'b00) begin
        m_owner = (rq == 2'b11) ? 1 - m_last : (rq[0] ? 0 : 1);
        m_last = m_owner;
        m_age = 1;
      end
      e_g0   = (m_owner == 0);
      e_g1   = (m_owner == 1);
      e_busy = (m_owner >= 0) || (m_guard > 0);
      e_scl  = (m_owner >= 0) ? sc[m_owner[0]] : 1'b1;
      e_oe   = (m_owner >= 0) ? so[m_owner[0]] : 1'b0;
    end
  end

  initial begin
    int k;
    bit seen;
    int nfail_rand;

    vt[0]  = '{9'b0_1_0_0_0_1_0_1_0, 7'b0_0_1_0_0_00};
    vt[1]  = '{9'b1_1_0_0_0_1_0_1_0, 7'b0_0_1_0_0_00};
    vt[2]  = '{9'b1_1_0_0_0_1_1_1_0, 7'b0_1_1_1_1_00};
    vt[3]  = '{9'b1_1_0_0_0_0_1_1_0, 7'b0_1_0_1_1_00};
    vt[4]  = '{9'b1_1_1_1_0_0_1_1_0, 7'b0_0_1_0_1_00};
    vt[5]  = '{9'b1_1_1_0_0_0_1_1_0, 7'b0_0_1_0_1_00};
    vt[6]  = '{9'b1_1_1_0_0_0_1_1_0, 7'b0_0_1_0_1_00};
    vt[7]  = '{9'b1_1_1_0_0_0_1_1_0, 7'b0_0_1_0_1_00};
    vt[8]  = '{9'b1_1_1_0_0_0_1_1_0, 7'b0_0_1_0_0_00};
    vt[9]  = '{9'b1_1_1_0_0_0_1_1_0, 7'b1_0_1_0_1_00};
    vt[10] = '{9'b1_1_1_1_0_1_0_0_1, 7'b1_0_0_1_1_00};
    vt[11] = '{9'b1_1_0_0_0_1_0_0_1, 7'b0_0_1_0_1_00};

    // Boot hold and exit latency
    do_reset();
    chk("reset_state", 32'(outs()), 32'(7'b0_0_1_0_0_00));
    REQ0 = 1'b1;
    seen = 0;
    repeat (50) begin
      @(negedge CLK_50);
      if (GNT0) seen = 1;
    end
    chk("boot_hold_gnt0", 32'(seen), 0);
    BRIDGE_RELEASE = 1'b1;
    @(negedge CLK_50);
    chk("boot_exit_1cyc_gnt0", 32'(GNT0), 0);
    @(negedge CLK_50);
    chk("boot_exit_2cyc_gnt0", 32'(GNT0), 1);

    // Vector table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      {BRIDGE_RELEASE, REQ0, REQ1, DONE0, DONE1, SCL0, SDA_OE0, SCL1, SDA_OE1} = vt[i].in;
      @(negedge CLK_50);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
    end

    // Watchdog on requester 1, sticky error, next grant
    do_reset();
    BRIDGE_RELEASE = 1'b1;
    REQ1 = 1'b1;
    k = 0;
    while (!GNT1 && k < 20) begin @(negedge CLK_50); k++; end
    chk("to_grant1", 32'(GNT1), 1);
    k = 0;
    while (GNT1 && k < 100) begin @(negedge CLK_50); k++; end
    chk("to_grant_len", 32'(k), T);
    chk("to_err_set", 32'(TIMEOUT_ERR), 2);
    REQ1 = 1'b0;
    REQ0 = 1'b1;
    k = 0;
    while (!GNT0 && k < 40) begin @(negedge CLK_50); k++; end
    chk("to_next_grant0", 32'(GNT0), 1);
    chk("to_err_sticky", 32'(TIMEOUT_ERR), 2);

    // Bridge drop during OWN0, then round-robin resumes with last=0
    SCL0 = 1'b0;
    SDA_OE0 = 1'b1;
    @(negedge CLK_50);
    BRIDGE_RELEASE = 1'b0;
    @(negedge CLK_50);
    chk("bdrop_outputs", 32'({GNT1, GNT0, CAMERA_I2C_SCL, CAMERA_I2C_SDA_OE, BUSY}), 32'(5'b00100));
    chk("bdrop_err", 32'(TIMEOUT_ERR), 2);
    REQ1 = 1'b1;
    BRIDGE_RELEASE = 1'b1;
    k = 0;
    while (!(GNT0 || GNT1) && k < 20) begin @(negedge CLK_50); k++; end
    chk("bdrop_rr_winner", 32'({GNT1, GNT0}), 2);

    // Asynchronous reset mid-grant
    SCL1 = 1'b0;
    SDA_OE1 = 1'b1;
    @(negedge CLK_50);
    chk("pre_areset_err", 32'(TIMEOUT_ERR), 2);
    #2 RESET_N = 1'b0;
    #1 chk("async_reset_outputs", 32'(outs()), 32'(7'b0_0_1_0_0_00));
    @(negedge CLK_50);
    RESET_N = 1'b1;

    // Random traffic against the reference model
    do_reset();
    BRIDGE_RELEASE = 1'b1;
    nfail_rand = 0;
    for (int i = 0; i < 3000 && nfail_rand < 10; i++) begin
      @(negedge CLK_50);
      if (outs() !== {e_g1, e_g0, e_scl, e_oe, e_busy, m_err}) nfail_rand++;
      chk("rand_vs_model", 32'(outs()), 32'({e_g1, e_g0, e_scl, e_oe, e_busy, m_err}));
      BRIDGE_RELEASE = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 15) == 0) REQ0 = ~REQ0;
      if ($urandom_range(0, 15) == 0) REQ1 = ~REQ1;
      DONE0 = ($urandom_range(0, 19) == 0);
      DONE1 = ($urandom_range(0, 19) == 0);
      SCL0 = 1'($urandom);
      SCL1 = 1'($urandom);
      SDA_OE0 = 1'($urandom);
      SDA_OE1 = 1'($urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
